regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter_pkg.sv | 12 +
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter_wb_slot.sv | 36 +++
 rtl/regfile_wb_arbiter.sv | 67 ++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, slot state and register decode helper
package regfile_wb_arbiter_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
        return {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
    endfunction
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: ALU/LSU writeback requests and register-file write port
interface regfile_wb_arbiter_if;
    import regfile_wb_arbiter_pkg::*;
    logic alu_valid;
    logic alu_ready;
    logic [REG_ADDR_W-1:0] alu_addr;
    logic [XLEN-1:0] alu_data;
    logic lsu_valid;
    logic lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_addr;
    logic [XLEN-1:0] lsu_data;
    logic wr_enable;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0] wr_data;
    logic [NUM_REGS-1:0] pending;

    modport master(
        output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
        input alu_ready, lsu_ready, wr_enable, wr_addr, wr_data, pending
    );
    modport slave(
        input alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
        output alu_ready, lsu_ready, wr_enable, wr_addr, wr_data, pending
    );
endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// wb_slot: one-entry writeback holding slot; writes to x0 are accepted and dropped
module wb_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic valid,
    input  logic [REG_ADDR_W-1:0] addr,
    input  logic [XLEN-1:0] data,
    input  logic grant,
    output logic ready,
    output logic load,
    output logic full,
    output logic [REG_ADDR_W-1:0] slot_addr,
    output logic [XLEN-1:0] slot_data
);
    slot_state_e state;

    assign full = state == SLOT_FULL;
    assign ready = !full || grant;
    assign load = valid && ready && addr != '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SLOT_EMPTY;
            slot_addr <= '0;
            slot_data <= '0;
        end else if (load) begin
            state <= SLOT_FULL;
            slot_addr <= addr;
            slot_data <= data;
        end else if (grant) begin
            state <= SLOT_EMPTY;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: ALU/LSU writeback arbiter, LSU-priority or round-robin with REGFILE_ARB_RR_EN
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input logic clk,
    input logic reset_n,
    regfile_wb_arbiter_if.slave bus
);
    logic alu_full, lsu_full, alu_load, lsu_load, alu_grant, lsu_grant;
    logic alu_older, lsu_pref, same_addr;
    logic [REG_ADDR_W-1:0] alu_slot_addr, lsu_slot_addr;
    logic [XLEN-1:0] alu_slot_data, lsu_slot_data;

    wb_slot alu_slot (
        .clk(clk), .reset_n(reset_n), .valid(bus.alu_valid), .addr(bus.alu_addr),
        .data(bus.alu_data), .grant(alu_grant), .ready(bus.alu_ready), .load(alu_load),
        .full(alu_full), .slot_addr(alu_slot_addr), .slot_data(alu_slot_data)
    );

    wb_slot lsu_slot (
        .clk(clk), .reset_n(reset_n), .valid(bus.lsu_valid), .addr(bus.lsu_addr),
        .data(bus.lsu_data), .grant(lsu_grant), .ready(bus.lsu_ready), .load(lsu_load),
        .full(lsu_full), .slot_addr(lsu_slot_addr), .slot_data(lsu_slot_data)
    );

`ifdef REGFILE_ARB_RR_EN
    logic rr_lsu;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rr_lsu <= 1'b1;
        else if (alu_grant || lsu_grant)
            rr_lsu <= alu_grant;
    end
    assign lsu_pref = rr_lsu;
`else
    assign lsu_pref = 1'b1;
`endif

    // Same-register writes must retire in arrival order, so age beats policy
    assign same_addr = alu_slot_addr == lsu_slot_addr;
    assign lsu_grant = lsu_full && (!alu_full || (same_addr ? !alu_older : lsu_pref));
    assign alu_grant = alu_full && !lsu_grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_older <= 1'b0;
            bus.wr_enable <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            alu_older <= alu_load ? 1'b0 : (lsu_load ? 1'b1 : alu_older);
            bus.wr_enable <= alu_grant || lsu_grant;
            if (lsu_grant) begin
                bus.wr_addr <= lsu_slot_addr;
                bus.wr_data <= lsu_slot_data;
            end else if (alu_grant) begin
                bus.wr_addr <= alu_slot_addr;
                bus.wr_data <= alu_slot_data;
            end
        end
    end

    assign bus.pending = ((lsu_full ? reg_onehot(lsu_slot_addr) : '0)
                        | (alu_full ? reg_onehot(alu_slot_addr) : '0)
                        | (bus.wr_enable ? reg_onehot(bus.wr_addr) : '0))
                        & {{(NUM_REGS-1){1'b1}}, 1'b0};
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: random and directed stimulus checked against a slot-level reference model
module tb_regfile_wb_arbiter;
    import regfile_wb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter_if bus();
    regfile_wb_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    // Model state: index 0 = LSU, 1 = ALU; stamp orders loads, LSU older on ties
    logic m_full[2];
    logic [4:0] m_addr[2];
    logic [31:0] m_data[2];
    int m_stamp[2];
    int last_g;
    int cyc;
    logic m_we;
    logic [4:0] m_wa;
    logic [31:0] m_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_full[i] = 1'b0;
            m_addr[i] = '0;
            m_data[i] = '0;
            m_stamp[i] = 0;
        end
        last_g = 1;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
    endtask

    function automatic int pick();
        if (m_full[0] && m_full[1]) begin
            if (m_addr[0] == m_addr[1])
                return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
`ifdef REGFILE_ARB_RR_EN
            return (last_g == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (m_full[0]) return 0;
        if (m_full[1]) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = '0;
        for (int k = 1; k < 32; k++)
            p[k] = (m_full[0] && m_addr[0] == k) || (m_full[1] && m_addr[1] == k) || (m_we && m_wa == k);
        return p;
    endfunction

    task automatic compare_all();
        int g;
        g = pick();
        chk("lsu_ready", 32'(bus.lsu_ready), 32'(!m_full[0] || g == 0));
        chk("alu_ready", 32'(bus.alu_ready), 32'(!m_full[1] || g == 1));
        chk("wr_enable", 32'(bus.wr_enable), 32'(m_we));
        chk("wr_addr", 32'(bus.wr_addr), 32'(m_wa));
        chk("wr_data", bus.wr_data, m_wd);
        chk("pending", bus.pending, exp_pending());
    endtask

    task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
        int g;
        logic [4:0] ga;
        logic [31:0] gd;
        logic v[2];
        logic [4:0] a[2];
        logic [31:0] d[2];
        @(negedge clk);
        compare_all();
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.lsu_valid = lv; bus.lsu_addr = la; bus.lsu_data = ld;
        v[0] = lv; a[0] = la; d[0] = ld;
        v[1] = av; a[1] = aa; d[1] = ad;
        if (reset_n) begin
            g = pick();
            ga = '0;
            gd = '0;
            if (g >= 0) begin
                ga = m_addr[g];
                gd = m_data[g];
            end
            for (int i = 0; i < 2; i++) begin
                if (v[i] && (!m_full[i] || g == i) && a[i] != 0) begin
                    m_full[i] = 1'b1;
                    m_addr[i] = a[i];
                    m_data[i] = d[i];
                    m_stamp[i] = 2 * cyc + i;
                end else if (g == i) begin
                    m_full[i] = 1'b0;
                end
            end
            m_we = g >= 0;
            if (g >= 0) begin
                m_wa = ga;
                m_wd = gd;
                last_g = g;
            end
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic async_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("rst_wr_enable", 32'(bus.wr_enable), 32'd0);
        chk("rst_pending", bus.pending, 32'd0);
        model_reset();
        idle(2);
        reset_n = 1'b1;
    endtask

    int wr_cnt;
    int alu_wr_cnt;

    initial begin
        bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_data = '0;
        cyc = 0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
        reset_n = 1'b1;
        idle(1);
        chk("release_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("release_lsu_ready", 32'(bus.lsu_ready), 32'd1);

        // single ALU write to x5
        step(1'b1, 5'd5, 32'h0000_00A5, 1'b0, 5'd0, 32'd0);
        idle(1);
        chk("x5_pending_held", bus.pending, 32'h20);
        chk("x5_no_early_write", 32'(bus.wr_enable), 32'd0);
        idle(1);
        chk("x5_wr_enable", 32'(bus.wr_enable), 32'd1);
        chk("x5_wr_addr", 32'(bus.wr_addr), 32'd5);
        chk("x5_wr_data", bus.wr_data, 32'hA5);
        chk("x5_pending_port", bus.pending, 32'h20);
        idle(1);
        chk("x5_done", 32'(bus.wr_enable), 32'd0);

        // simultaneous ALU x3 / LSU x4
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        chk("dual_alu_ready", 32'(bus.alu_ready), 32'd1);
        chk("dual_lsu_ready", 32'(bus.lsu_ready), 32'd1);
        idle(2);
        chk("dual_first_addr", 32'(bus.wr_addr), 32'd4);
        chk("dual_first_data", bus.wr_data, 32'h22);
        idle(1);
        chk("dual_second_addr", 32'(bus.wr_addr), 32'd3);
        chk("dual_second_data", bus.wr_data, 32'h11);
        idle(2);

`ifndef REGFILE_ARB_RR_EN
        // older ALU x7 beats LSU priority on same destination
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'hA);
        step(1'b1, 5'd7, 32'h1, 1'b1, 5'd10, 32'hB);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2);
        chk("order_w0", bus.wr_data, 32'hA);
        idle(1);
        chk("order_w1", bus.wr_data, 32'hB);
        idle(1);
        chk("order_x7_first", {bus.wr_addr, bus.wr_data[26:0]}, {5'd7, 27'h1});
        idle(1);
        chk("order_x7_second", {bus.wr_addr, bus.wr_data[26:0]}, {5'd7, 27'h2});
        idle(2);
`endif

        // both stream continuously
        wr_cnt = 0;
        alu_wr_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 5'd1, 32'hA000_0000 + i, 1'b1, 5'd2, 32'hB000_0000 + i);
            if (i >= 2) begin
                wr_cnt += int'(bus.wr_enable);
                alu_wr_cnt += int'(bus.wr_enable && bus.wr_addr == 5'd1);
            end
        end
        chk("stream_throughput", 32'(wr_cnt), 32'd6);
`ifdef REGFILE_ARB_RR_EN
        chk("stream_alu_share", 32'(alu_wr_cnt), 32'd3);
`else
        chk("stream_alu_share", 32'(alu_wr_cnt), 32'd0);
`endif
        idle(4);

        // x0 request is accepted and dropped
        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0);
        chk("x0_ready", 32'(bus.alu_ready), 32'd1);
        idle(1);
        chk("x0_no_write", 32'(bus.wr_enable), 32'd0);
        idle(1);
        chk("x0_pending", bus.pending, 32'd0);

        // reset with both slots full
        step(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        idle(1);
        chk("full_pending", bus.pending, 32'h300);
        async_reset();
        idle(2);
        chk("post_reset_no_write", 32'(bus.wr_enable), 32'd0);

        // randomized traffic with a mid-run reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) async_reset();
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
